// File: rtl/accel_host_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// accel_host_sequencer_if : accelerator write/read slave bus
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface accel_host_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RDATA_W = 32
);
  logic               write_en;
  logic               write_rdy;
  logic [ADDR_W-1:0]  write_addr;
  logic [DATA_W-1:0]  write_data;
  logic               interrupt;
  logic               read_en;
  logic               read_rdy;
  logic [ADDR_W-1:0]  read_addr;
  logic               read_data_rdy;
  logic               read_data_vld;
  logic [RDATA_W-1:0] read_data;

  // Host side drives requests and consumes read data.
  modport master (
    output write_en, write_addr, write_data, read_en, read_addr, read_data_rdy,
    input  write_rdy, interrupt, read_rdy, read_data_vld, read_data
  );

  modport slave (
    input  write_en, write_addr, write_data, read_en, read_addr, read_data_rdy,
    output write_rdy, interrupt, read_rdy, read_data_vld, read_data
  );
endinterface
`default_nettype wire

// File: rtl/accel_host_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// accel_host_sequencer : streams config, times the job, sweeps activations
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module accel_host_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RDATA_W   = 32,
  parameter int PE_NUM    = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [11:0]           out_act_no,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  cfg_last,
  accel_host_sequencer_if.master acc,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [11:0]           res_idx,
  output logic [15:0]           res_act,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           exec_cycles
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG      = 3'd1,
    S_WAIT_INT = 3'd2,
    S_READ     = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [5:0] c_PE_LAST   = 6'(PE_NUM - 1);
  localparam logic [3:0] c_MAX_OUTST = 4'(MAX_OUTST);

  state_t              r_state;
  logic [11:0]         r_act_no;
  logic                r_cfg_done;
  logic                r_write_en;
  logic [ADDR_W-1:0]   r_write_addr;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_read_en;
  logic [ADDR_W-1:0]   r_read_addr;
  logic [31:0]         r_exec;
  logic [5:0]          r_pe_idx;
  logic [5:0]          r_act_addr;
  logic [11:0]         r_issued;
  logic [11:0]         r_received;
  logic [3:0]          r_outst;

  logic                w_rd_phase;
  logic                w_cfg_acc;
  logic                w_rd_acc;
  logic                w_issue;
  logic [15:0]         w_raddr16;
  logic [ADDR_W-1:0]   w_raddr;
  logic [3:0]          w_outst_nxt;

  assign w_rd_phase = (r_state == S_READ) || (r_state == S_DRAIN);
  // write_en in the mask limits the config stream to one write every two cycles
  assign cfg_rdy    = (r_state == S_CFG) & acc.write_rdy & ~r_write_en;
  assign w_cfg_acc  = cfg_vld & cfg_rdy;

  assign acc.read_data_rdy = res_rdy & w_rd_phase;
  assign w_rd_acc          = acc.read_data_vld & acc.read_data_rdy;
  assign res_vld           = acc.read_data_vld & w_rd_phase;
  assign res_idx           = acc.read_data[27:16];
  assign res_act           = acc.read_data[15:0];

  assign w_issue = (r_state == S_READ) & acc.read_rdy & ~r_read_en &
                   (r_outst < c_MAX_OUTST) & (r_issued < r_act_no);
  assign w_raddr16   = {r_pe_idx, 4'b0000, r_act_addr};
  assign w_raddr     = ADDR_W'(w_raddr16);
  assign w_outst_nxt = r_outst + 4'(w_issue) - 4'(w_rd_acc);

  assign acc.write_en   = r_write_en;
  assign acc.write_addr = r_write_addr;
  assign acc.write_data = r_write_data;
  assign acc.read_en    = r_read_en;
  assign acc.read_addr  = r_read_addr;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign exec_cycles    = r_exec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_act_no     <= '0;
      r_cfg_done   <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_read_en    <= 1'b0;
      r_read_addr  <= '0;
      r_exec       <= '0;
      r_pe_idx     <= '0;
      r_act_addr   <= '0;
      r_issued     <= '0;
      r_received   <= '0;
      r_outst      <= '0;
    end else begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_read_en    <= 1'b0;
      r_read_addr  <= '0;
      r_outst      <= w_outst_nxt;
      if (w_rd_acc) r_received <= r_received + 12'd1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_CFG;
            r_act_no   <= out_act_no;
            r_exec     <= '0;
            r_cfg_done <= 1'b0;
            r_pe_idx   <= '0;
            r_act_addr <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_outst    <= '0;
          end
        end
        S_CFG: begin
          if (w_cfg_acc) begin
            r_write_en   <= 1'b1;
            r_write_addr <= cfg_addr;
            r_write_data <= cfg_data;
            r_cfg_done   <= cfg_last;
          end else if (r_write_en && r_cfg_done) begin
            // Timing starts with the cycle right after the final write
            r_state <= S_WAIT_INT;
            r_exec  <= 32'd1;
          end
        end
        S_WAIT_INT: begin
          if (acc.interrupt) begin
            r_state <= (r_act_no == 12'd0) ? S_DONE : S_READ;
          end else if (r_exec != 32'hFFFF_FFFF) begin
            r_exec <= r_exec + 32'd1;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_read_en   <= 1'b1;
            r_read_addr <= w_raddr;
            r_issued    <= r_issued + 12'd1;
            if (r_pe_idx == c_PE_LAST) begin
              r_pe_idx   <= '0;
              r_act_addr <= r_act_addr + 6'd1;
            end else begin
              r_pe_idx <= r_pe_idx + 6'd1;
            end
          end
          if (r_issued == r_act_no) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_received == r_act_no) && (r_outst == 4'd0)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_host_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_accel_host_sequencer : table-driven jobs against an accelerator model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_accel_host_sequencer;
  localparam int ADDR_W = 16, DATA_W = 32, RDATA_W = 32, PE_NUM = 64, MAX_OUTST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, cfg_vld, cfg_rdy, cfg_last;
  logic [11:0]        out_act_no;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [DATA_W-1:0]  cfg_data;
  logic               res_vld, res_rdy, busy, done;
  logic [11:0]        res_idx;
  logic [15:0]        res_act;
  logic [31:0]        exec_cycles;

  accel_host_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDATA_W(RDATA_W)) acc ();

  accel_host_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDATA_W(RDATA_W), .PE_NUM(PE_NUM), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .out_act_no(out_act_no),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .acc(acc), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_idx(res_idx), .res_act(res_act), .busy(busy), .done(done),
    .exec_cycles(exec_cycles)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        last;
    logic [15:0] exp_waddr;
    logic [31:0] exp_wdata;
  } cfg_t;

  typedef struct {
    int          act_no;
    int          int_delay;
    int          lat;
    int          stall_at;
    int          exp_exec;
    int          exp_peak;
    logic [15:0] exp_last_addr;
  } job_t;

  typedef struct { int due; int n; } rsp_t;

  cfg_t cfg_tab [3];
  job_t jobs [7];

  int n_checks = 0, n_err = 0;
  int mon_iss, mon_res, mon_outst, mon_peak, mon_done, mon_viol;
  logic [15:0] mon_last_addr;
  time mon_last_res_t, mon_done_t;
  int job_id = 0, cur_lat = 3, cur_stall_at = -1;
  logic flush = 1'b1;

  function automatic logic [15:0] act_of(input int n);
    return 16'(n * 37 - 500);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {acc.write_en, acc.read_en, cfg_rdy, res_vld, acc.read_data_rdy, busy, done}, 0);
    check({tag, "_wbus"}, {acc.write_addr, acc.write_data}, 0);
    check({tag, "_raddr"}, acc.read_addr, 0);
    check({tag, "_exec"}, exec_cycles, 0);
  endtask

  // Accelerator model: in-order read returns after cur_lat cycles, plus res_rdy stall
  initial begin
    rsp_t q[$];
    int mcyc = 0, m_n = 0, seen_job = 0, stall_left = 0;
    logic hs, ren, stall_arm = 1'b0;
    acc.read_data_vld = 1'b0;
    acc.read_data     = '0;
    res_rdy           = 1'b1;
    forever begin
      @(negedge clk);
      hs  = acc.read_data_vld & acc.read_data_rdy;
      ren = acc.read_en;
      @(posedge clk); #1;
      mcyc++;
      if (flush || seen_job != job_id) begin
        q.delete(); m_n = 0; seen_job = job_id; hs = 0; ren = 0;
        stall_left = 0; stall_arm = (cur_stall_at >= 0);
      end
      if (hs && q.size() > 0) void'(q.pop_front());
      if (ren) begin
        q.push_back('{due: mcyc + cur_lat - 1, n: m_n});
        m_n++;
      end
      if (stall_arm && mon_res >= cur_stall_at) begin stall_arm = 0; stall_left = 20; end
      if (stall_left > 0) begin res_rdy = 1'b0; stall_left--; end
      else res_rdy = 1'b1;
      if (q.size() > 0 && q[0].due <= mcyc) begin
        acc.read_data_vld = 1'b1;
        acc.read_data     = {4'b0, 12'(q[0].n), act_of(q[0].n)};
      end else begin
        acc.read_data_vld = 1'b0;
      end
    end
  end

  // Bus monitor: address order, result order, outstanding depth, handshake rules
  initial begin
    logic [15:0] exp_addr;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (cfg_rdy && acc.write_en) mon_viol++;
        if (acc.read_data_rdy && (!res_rdy || !busy)) mon_viol++;
        if (acc.read_en) begin
          exp_addr = 16'(((mon_iss % PE_NUM) << 10) | (mon_iss / PE_NUM));
          check("read_addr", acc.read_addr, exp_addr);
          mon_last_addr = acc.read_addr;
          mon_iss++; mon_outst++;
        end
        if (res_vld && res_rdy) begin
          check("res_idx", res_idx, 12'(mon_res));
          check("res_act", res_act, act_of(mon_res));
          mon_res++; mon_outst--; mon_last_res_t = $time;
        end
        if (mon_outst > mon_peak) mon_peak = mon_outst;
        if (done) begin mon_done++; mon_done_t = $time; end
      end
    end
  end

  task automatic run_pre(input job_t j);
    int w;
    time t_prev;
    cur_lat = j.lat; cur_stall_at = j.stall_at; job_id++;
    mon_iss = 0; mon_res = 0; mon_outst = 0; mon_peak = 0; mon_done = 0; mon_viol = 0;
    mon_last_addr = 16'hFFFF; mon_last_res_t = 0; mon_done_t = 0;
    out_act_no = 12'(j.act_no); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_vld = 1'b1; cfg_addr = cfg_tab[i].addr; cfg_data = cfg_tab[i].data; cfg_last = cfg_tab[i].last;
      w = 0;
      do begin @(negedge clk); w++; end while (!cfg_rdy && w < 20);
      @(posedge clk); #1;
      cfg_vld = 1'b0; cfg_last = 1'b0;
      check("cfg_accepted", (w < 20), 1);
      check("write_en", acc.write_en, 1);
      check("write_addr", acc.write_addr, cfg_tab[i].exp_waddr);
      check("write_data", acc.write_data, cfg_tab[i].exp_wdata);
      if (i > 0) check("write_spacing_ns", $time - t_prev, 20);
      t_prev = $time;
    end
    for (int k = 1; k <= j.int_delay; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check("exec_first", exec_cycles, 1);
        check("write_cleared", {acc.write_en, acc.write_addr, acc.write_data}, 0);
      end
    end
    acc.interrupt = 1'b1;
    @(posedge clk); #1;
    acc.interrupt = 1'b0;
    check("exec_frozen", exec_cycles, j.exp_exec);
  endtask

  task automatic run_post(input job_t j);
    int w = 0;
    while (mon_done == 0 && w < 5000) begin @(posedge clk); #1; w++; end
    repeat (3) begin @(posedge clk); #1; end
    check("done_pulses", mon_done, 1);
    check("busy_idle", busy, 0);
    check("exec_hold", exec_cycles, j.exp_exec);
    check("results", mon_res, j.act_no);
    check("reads_issued", mon_iss, j.act_no);
    check("last_read_addr", mon_last_addr, j.exp_last_addr);
    check("handshake_viol", mon_viol, 0);
    if (j.exp_peak >= 0) check("outst_peak", mon_peak, j.exp_peak);
    else check("outst_peak_le_max", (mon_peak <= MAX_OUTST), 1);
    if (j.act_no > 0) check("done_after_last", (mon_done_t > mon_last_res_t), 1);
  endtask

  initial begin
    int w;
    cfg_tab[0] = '{16'h0010, 32'hA, 1'b0, 16'h0010, 32'hA};
    cfg_tab[1] = '{16'h0014, 32'hB, 1'b0, 16'h0014, 32'hB};
    cfg_tab[2] = '{16'h0018, 32'hC, 1'b1, 16'h0018, 32'hC};
    //          act  dly lat stall exec peak last_addr
    jobs[0] = '{  0, 50, 3,  -1, 50, -1, 16'hFFFF};
    jobs[1] = '{130, 10, 3,  -1, 10, -1, 16'h0402};
    jobs[2] = '{130,  5, 3,  40,  5,  4, 16'h0402};
    jobs[3] = '{ 64,  1, 1,  -1,  1, -1, 16'hFC00};
    jobs[4] = '{  1,  2, 6,  -1,  2,  1, 16'h0000};
    jobs[5] = '{130,  7, 5,  -1,  7, -1, 16'h0402};
    jobs[6] = '{  3,  4, 3,  -1,  4, -1, 16'h0800};

    rst = 1'b0; start = 1'b0; out_act_no = '0;
    cfg_vld = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
    acc.write_rdy = 1'b1; acc.read_rdy = 1'b1; acc.interrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1; flush = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_pre(jobs[i]);
      run_post(jobs[i]);
    end

    // Abort a sweep asynchronously with two reads in flight
    run_pre(jobs[5]);
    w = 0;
    while (!(mon_outst == 2 && busy) && w < 2000) begin @(negedge clk); w++; end
    check("rst_setup_outst2", (w < 2000), 1);
    #2;
    rst = 1'b0; flush = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    run_pre(jobs[6]);
    run_post(jobs[6]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accel_host_sequencer.md
Name: accel_host_sequencer

Overview:
Host-side controller that drives the Accelerator's write/read slave interface without a CPU. It streams configuration words into the write port, waits for the accelerator interrupt, and measures the execution cycles. It then sweeps output-activation read addresses in PE-major order and forwards the returned activations on a valid/ready result stream. It replaces the manual bus sequencing currently done by bench tasks and can be reused in an FPGA wrapper.

Parameters:
ADDR_W, 16, accelerator address bus width
DATA_W, 32, accelerator write data width
RDATA_W, 32, accelerator read data width
PE_NUM, 64, number of PEs swept per activation address
MAX_OUTST, 4, maximum read requests issued but not yet returned (power of 2, max 8)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; begins a job (sampled only in IDLE)
out_act_no  in  12  number of output activations to read back (latched on start)
cfg_vld  in  1  configuration word valid
cfg_rdy  out  1  configuration word accepted this cycle
cfg_addr  in  ADDR_W  configuration write address
cfg_data  in  DATA_W  configuration write data
cfg_last  in  1  marks the final configuration word
write_en  out  1  accelerator write enable
write_rdy  in  1  accelerator write ready
write_addr  out  ADDR_W  accelerator write address
write_data  out  DATA_W  accelerator write data
interrupt  in  1  accelerator completion interrupt (level)
read_en  out  1  accelerator read enable
read_rdy  in  1  accelerator read ready
read_addr  out  ADDR_W  accelerator read address
read_data_rdy  out  1  ready for accelerator read data
read_data_vld  in  1  accelerator read data valid
read_data  in  RDATA_W  [27:16] activation index, [15:0] signed activation
res_vld  out  1  result valid
res_rdy  in  1  result ready
res_idx  out  12  activation index (read_data[27:16])
res_act  out  16  activation value (read_data[15:0])
busy  out  1  high whenever state is not IDLE
done  out  1  single-cycle pulse when the job completes
exec_cycles  out  32  cycles from last configuration write to interrupt

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0: write_en, read_en, write_addr/data, read_addr, exec_cycles, busy, done, cfg_rdy, res_vld, read_data_rdy. All counters are 0.
- FSM states: IDLE, CFG, WAIT_INT, READ, DRAIN, DONE.
- IDLE: on start, latch out_act_no, go to CFG, and clear exec_cycles.
- CFG:
  - cfg_rdy = write_rdy & ~write_en (combinational). This gives at most one write per 2 cycles.
  - On accept (cfg_vld & cfg_rdy), register write_en=1 with addr/data for exactly 1 cycle. The next cycle write_en=0 and addr/data=0.
  - Accepting a word with cfg_last=1 moves to WAIT_INT on the following cycle, after that final write_en cycle.
- WAIT_INT:
  - exec_cycles increments each cycle, saturating at 32'hFFFF_FFFF. It starts at 1 in the first WAIT_INT cycle.
  - When interrupt=1 is sampled, exec_cycles freezes.
  - Then go to READ; if the latched out_act_no==0, go to DONE instead.
  - interrupt is ignored in every other state.
- READ, address generation:
  - read_addr = {pe_idx[5:0], 4'b0, act_addr[5:0]} for ADDR_W=16; the remaining upper bits are 0.
  - Sweep order: pe_idx 0..PE_NUM-1 first; on wrap to 0, act_addr increments.
- READ, issue rule:
  - read_en is registered and asserted for 1 cycle per request.
  - Issue only when read_rdy & ~read_en & outstanding<MAX_OUTST & issued<out_act_no.
  - After issued==out_act_no, go to DRAIN.
- Outstanding counter: +1 on issue, -1 on accepted read data (read_data_vld & read_data_rdy). Both in the same cycle leaves it unchanged. It never exceeds MAX_OUTST.
- Result path:
  - read_data_rdy = res_rdy while in READ or DRAIN; 0 otherwise.
  - res_vld = read_data_vld in those states. res_idx/res_act are combinational slices of read_data (zero latency).
  - received increments on each res_vld & res_rdy.
- DRAIN: when received==out_act_no and outstanding==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle that IDLE is entered. exec_cycles holds until the next start.
- start in any non-IDLE state is ignored.
- Read data arriving outside READ/DRAIN is not accepted (read_data_rdy=0).
- Reset mid-job aborts immediately to IDLE. The accelerator must be reset separately.

Test Plan:
- 3 cfg words (0x0010/0xA, 0x0014/0xB, 0x0018/0xC, last on third), write_rdy=1 -> 3 write_en pulses, one each, 2 cycles apart, with matching addr/data; cfg_rdy never high while write_en=1.
- interrupt asserted 50 cycles after final write_en -> exec_cycles=50 and frozen; out_act_no=0 -> done pulse, no read_en ever issued.
- out_act_no=130, read_rdy=1, accelerator returns data 3 cycles after each read_en -> read_addr sequence 0x0000, 0x0400, …, 0xFC00, 0x0001, …, 0xFC01, then 0x0002 and 0x0402 last; 130 results; outstanding peaks at ≤4.
- res_rdy held 0 for 20 cycles mid-sweep -> read_data_rdy=0, no result lost or duplicated, issue stalls at MAX_OUTST=4.
- Simultaneous issue and return every cycle -> outstanding stays constant; done only after final return.
- rst=0 asserted in READ with 2 outstanding -> all outputs 0 asynchronously; a new start after release completes a fresh job correctly.
